// File: rtl/button_press_classifier_pkg.sv
// Shared definitions for the button press classifier: FSM state encoding and
// default timing parameters.
package button_press_classifier_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSED  = 2'd1,
    LONGHELD = 2'd2
  } state_e;

  localparam int unsigned LONG_CYCLES_DEF   = 1000;
  localparam int unsigned REPEAT_CYCLES_DEF = 250;
  localparam int unsigned CNT_W_DEF         = 16;

endpackage

// File: rtl/button_press_classifier_counter.sv
// Press duration counter: synchronous clear has priority over increment;
// at_tc_o flags that the current count equals the selected terminal count.
module press_cycle_counter
  import button_press_classifier_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             at_tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_tc_o = (cnt_q == tc_i);

endmodule

// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into short-press, long-press and
// auto-repeat pulses, plus a held level. All outputs are registered.
module button_press_classifier
  import button_press_classifier_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic IPTCLK,
  input  logic IPTRST,
  input  logic IPTBTN,
  output logic OUTSHORT,
  output logic OUTLONG,
  output logic OUTREPEAT,
  output logic OUTHELD
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("CNT_W out of range");
  end
  if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) > CNT_MAX) begin : g_bad_long
    $error("LONG_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) > CNT_MAX) begin : g_bad_repeat
    $error("REPEAT_CYCLES out of range");
  end

  state_e           state_q;
  state_e           state_d;
  logic             short_q;
  logic             long_q;
  logic             repeat_q;
  logic             held_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic             at_tc;
  logic [CNT_W-1:0] tc_sel;

  // The counter always runs against the threshold of the current state, so
  // a single comparator serves both long-press and repeat boundaries.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    tc_sel  = (state_q == LONGHELD) ? REPEAT_TC : LONG_TC;
    unique case (state_q)
      IDLE: begin
        if (IPTBTN) begin
          state_d = PRESSED;
          cnt_en  = 1'b1;
        end
      end
      PRESSED: begin
        if (!IPTBTN) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (at_tc) begin
          state_d = LONGHELD;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      LONGHELD: begin
        if (!IPTBTN) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (at_tc) begin
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  press_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk_i  (IPTCLK),
    .rst_i  (IPTRST),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_i   (tc_sel),
    .at_tc_o(at_tc)
  );

  always_ff @(posedge IPTCLK or posedge IPTRST) begin
    if (IPTRST) begin
      state_q  <= IDLE;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      short_q  <= (state_q == PRESSED) && !IPTBTN;
      long_q   <= (state_q == PRESSED) && IPTBTN && at_tc;
      repeat_q <= (state_q == LONGHELD) && IPTBTN && at_tc;
      held_q   <= (state_d != IDLE);
    end
  end

  assign OUTSHORT  = short_q;
  assign OUTLONG   = long_q;
  assign OUTREPEAT = repeat_q;
  assign OUTHELD   = held_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier with LONG_CYCLES=8,
// REPEAT_CYCLES=4; reference model works on run lengths of high samples.
module tb_button_press_classifier;

  localparam int unsigned L = 8;
  localparam int unsigned R = 4;

  logic IPTCLK = 1'b0;
  logic IPTRST;
  logic IPTBTN;
  logic OUTSHORT, OUTLONG, OUTREPEAT, OUTHELD;

  button_press_classifier #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_W        (8)
  ) dut (
    .IPTCLK   (IPTCLK),
    .IPTRST   (IPTRST),
    .IPTBTN   (IPTBTN),
    .OUTSHORT (OUTSHORT),
    .OUTLONG  (OUTLONG),
    .OUTREPEAT(OUTREPEAT),
    .OUTHELD  (OUTHELD)
  );

  always #5 IPTCLK = ~IPTCLK;

  int checks = 0;
  int errors = 0;

  // Model: number of consecutive high samples in the current press.
  int unsigned run = 0;
  logic e_s = 1'b0, e_l = 1'b0, e_r = 1'b0, e_h = 1'b0;
  int unsigned n_s, n_l, n_r, n_h;

  typedef struct {
    int unsigned len;
    int unsigned shorts;
    int unsigned longs;
    int unsigned reps;
    int unsigned helds;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (short,long,repeat,held) at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_sample(input logic b);
    e_s = 1'b0; e_l = 1'b0; e_r = 1'b0; e_h = 1'b0;
    if (IPTRST) begin
      run = 0;
    end else if (b) begin
      run++;
      e_h = 1'b1;
      if (run == L) e_l = 1'b1;
      else if (run > L && (run - L) % R == 0) e_r = 1'b1;
    end else begin
      if (run >= 1 && run < L) e_s = 1'b1;
      run = 0;
    end
  endtask

  task automatic cycle(input logic b, input string name);
    IPTBTN = b;
    @(posedge IPTCLK);
    model_sample(b);
    @(negedge IPTCLK);
    check(name, {OUTSHORT, OUTLONG, OUTREPEAT, OUTHELD}, {e_s, e_l, e_r, e_h});
    checks++;
    if ($countones({OUTSHORT, OUTLONG, OUTREPEAT}) > 1) begin
      errors++;
      $display("FAIL exclusive: got %b expected at most one pulse", {OUTSHORT, OUTLONG, OUTREPEAT});
    end
    n_s += int'(OUTSHORT);
    n_l += int'(OUTLONG);
    n_r += int'(OUTREPEAT);
    n_h += int'(OUTHELD);
  endtask

  task automatic clear_counts();
    n_s = 0; n_l = 0; n_r = 0; n_h = 0;
  endtask

  // Press for pre samples, assert reset between edges, hold it over
  // rst_edges edges with the button high, then expect OUTLONG L samples later.
  task automatic reset_mid_press(input int unsigned pre, input int unsigned rst_edges, input string name);
    for (int unsigned i = 0; i < pre; i++) cycle(1'b1, {name, "_pre"});
    #2;
    IPTRST = 1'b1;
    #1;
    check({name, "_async"}, {OUTSHORT, OUTLONG, OUTREPEAT, OUTHELD}, 4'b0000);
    for (int unsigned i = 0; i < rst_edges; i++) cycle(1'b1, {name, "_in_rst"});
    IPTRST = 1'b0;
    clear_counts();
    for (int unsigned i = 0; i < L - 1; i++) cycle(1'b1, {name, "_post"});
    check({name, "_no_early_pulse"}, {n_s[0], n_l[0], n_r[0], 1'b1}, 4'b0001);
    cycle(1'b1, {name, "_long"});
    check({name, "_long_at_L"}, {OUTSHORT, OUTLONG, OUTREPEAT, OUTHELD}, 4'b0101);
    cycle(1'b0, {name, "_rel"});
    cycle(1'b0, {name, "_idle"});
  endtask

  initial begin
    tbl[0] = '{len: 1,  shorts: 1, longs: 0, reps: 0, helds: 1};
    tbl[1] = '{len: 2,  shorts: 1, longs: 0, reps: 0, helds: 2};
    tbl[2] = '{len: 7,  shorts: 1, longs: 0, reps: 0, helds: 7};
    tbl[3] = '{len: 8,  shorts: 0, longs: 1, reps: 0, helds: 8};
    tbl[4] = '{len: 11, shorts: 0, longs: 1, reps: 0, helds: 11};
    tbl[5] = '{len: 12, shorts: 0, longs: 1, reps: 1, helds: 12};
    tbl[6] = '{len: 16, shorts: 0, longs: 1, reps: 2, helds: 16};
    tbl[7] = '{len: 17, shorts: 0, longs: 1, reps: 2, helds: 17};

    IPTRST = 1'b1;
    IPTBTN = 1'b0;
    clear_counts();
    #1;
    check("reset_state", {OUTSHORT, OUTLONG, OUTREPEAT, OUTHELD}, 4'b0000);
    @(negedge IPTCLK);
    @(negedge IPTCLK);
    check("reset_held", {OUTSHORT, OUTLONG, OUTREPEAT, OUTHELD}, 4'b0000);
    IPTRST = 1'b0;
    cycle(1'b0, "idle");

    foreach (tbl[k]) begin
      clear_counts();
      for (int unsigned i = 0; i < tbl[k].len; i++) cycle(1'b1, $sformatf("tbl%0d_high", k));
      cycle(1'b0, $sformatf("tbl%0d_release", k));
      cycle(1'b0, $sformatf("tbl%0d_quiet", k));
      checks++;
      if (n_s != tbl[k].shorts || n_l != tbl[k].longs || n_r != tbl[k].reps || n_h != tbl[k].helds) begin
        errors++;
        $display("FAIL tbl%0d_counts: got s=%0d l=%0d r=%0d h=%0d expected s=%0d l=%0d r=%0d h=%0d",
                 k, n_s, n_l, n_r, n_h, tbl[k].shorts, tbl[k].longs, tbl[k].reps, tbl[k].helds);
      end
    end

    reset_mid_press(3, 3, "rst_long_hold");
    reset_mid_press(4, 1, "rst_sample5");

    for (int unsigned it = 0; it < 150; it++) begin
      int unsigned hi;
      int unsigned lo;
      hi = $urandom_range(1, 22);
      lo = $urandom_range(1, 3);
      for (int unsigned i = 0; i < hi; i++) begin
        if ($urandom_range(0, 59) == 0) begin
          #2;
          IPTRST = 1'b1;
          cycle(1'b1, "rnd_rst");
          IPTRST = 1'b0;
        end else begin
          cycle(1'b1, "rnd_high");
        end
      end
      for (int unsigned i = 0; i < lo; i++) cycle(1'b0, "rnd_low");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
